// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART serializer between N byte-stream
// requesters; a grant ends on the last byte, after MAX_BURST bytes, or on an idle timeout.
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   o_grant,
  output logic           o_tx_start,
  output logic [7:0]     o_tx_data,
  input  logic           i_tx_busy,
  input  logic           i_tx_done,
  output logic           o_timeout
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [N-1:0] GRANT_ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_START, S_WAIT} state_t;

  state_t          state_q;
  logic [IW-1:0]   grant_idx_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [7:0]      data_q;
  logic            last_q;
  logic [BW-1:0]   burst_cnt_q;
  logic [TW-1:0]   idle_cnt_q;
  logic [N-1:0]    grant_q;
  logic            tx_start_q;
  logic            timeout_q;

  logic            win_any;
  logic [IW-1:0]   win_idx;
  logic [IW:0]     scan_sum;
  logic [IW-1:0]   scan_idx;
  logic            own_valid;
  logic [7:0]      own_data;
  logic            own_last;
  logic [IW-1:0]   rr_ptr_d;
  logic [BW-1:0]   burst_cnt_d;
  logic [TW-1:0]   idle_cnt_d;

  assign o_grant    = grant_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = data_q;
  assign o_timeout  = timeout_q;

  assign own_valid   = req_valid[grant_idx_q];
  assign own_data    = req_data[8*grant_idx_q +: 8];
  assign own_last    = req_last[grant_idx_q];
  assign rr_ptr_d    = (grant_idx_q == IW'(N-1)) ? {IW{1'b0}} : grant_idx_q + IW'(1);
  assign burst_cnt_d = burst_cnt_q + BW'(1);
  assign idle_cnt_d  = (idle_cnt_q == TW'(IDLE_TIMEOUT)) ? idle_cnt_q : idle_cnt_q + TW'(1);

  // Rotating priority scan starting at rr_ptr; the first valid requester wins.
  always_comb begin
    win_any  = 1'b0;
    win_idx  = rr_ptr_q;
    scan_sum = {(IW+1){1'b0}};
    scan_idx = {IW{1'b0}};
    for (int k = 0; k < N; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(N)) begin
        scan_sum = scan_sum - (IW+1)'(N);
      end else begin
        scan_sum = scan_sum;
      end
      scan_idx = scan_sum[IW-1:0];
      if (!win_any && req_valid[scan_idx]) begin
        win_any = 1'b1;
        win_idx = scan_idx;
      end else begin
        win_any = win_any;
      end
    end
  end

  // Only the owner may hand over a byte, and only while the serializer is free.
  always_comb begin
    req_ready = {N{1'b0}};
    if (state_q == S_SEND && !i_tx_busy) begin
      req_ready[grant_idx_q] = 1'b1;
    end else begin
      req_ready = {N{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_idx_q <= {IW{1'b0}};
      rr_ptr_q    <= {IW{1'b0}};
      data_q      <= 8'h00;
      last_q      <= 1'b0;
      burst_cnt_q <= {BW{1'b0}};
      idle_cnt_q  <= {TW{1'b0}};
      grant_q     <= {N{1'b0}};
      tx_start_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_any) begin
            grant_idx_q <= win_idx;
            grant_q     <= GRANT_ONE << win_idx;
            burst_cnt_q <= {BW{1'b0}};
            idle_cnt_q  <= {TW{1'b0}};
            state_q     <= S_SEND;
          end
        end
        S_SEND: begin
          if (own_valid && !i_tx_busy) begin
            data_q      <= own_data;
            last_q      <= own_last;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= {TW{1'b0}};
            tx_start_q  <= 1'b1;
            state_q     <= S_START;
          end else if (!own_valid) begin
            idle_cnt_q <= idle_cnt_d;
            // Stalled owner: give the serializer to someone else without ending its packet.
            if (idle_cnt_d >= TW'(IDLE_TIMEOUT)) begin
              timeout_q <= 1'b1;
              rr_ptr_q  <= rr_ptr_d;
              grant_q   <= {N{1'b0}};
              state_q   <= S_IDLE;
            end
          end
        end
        S_START: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_tx_done) begin
            if (last_q || burst_cnt_q == BW'(MAX_BURST)) begin
              rr_ptr_q <= rr_ptr_d;
              grant_q  <= {N{1'b0}};
              state_q  <= S_IDLE;
            end else begin
              state_q <= S_SEND;
            end
          end
        end
        default: begin
          grant_q <= {N{1'b0}};
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
